// File: rtl/bit_serializer_mlane.sv
// Multi-lane bit serializer: snapshots a per-lane bit array on start and shifts
// it out one bit per synchronized clk_data rising edge, ascending or descending.
module bit_serializer_mlane #(
  parameter int BIT_CHIP  = 6,
  parameter int NODE      = 16,
  parameter int LANES     = 2,
  parameter int FRAME_LEN = BIT_CHIP * NODE,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic                       clk_main,
  input  logic                       clr,
  input  logic                       clk_data,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       msb_first,
  input  logic                       continuous,
  input  logic [LANES*FRAME_LEN-1:0] array_in,
  output logic [LANES-1:0]           data_out,
  output logic                       busy,
  output logic                       frame_done,
  output logic [CNT_W-1:0]           bit_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_t;

  state_t                     state, state_n;
  logic                       s1, s2, s3, edge_q;
  logic [LANES*FRAME_LEN-1:0] snap, snap_n;
  logic                       mode_r, mode_n;
  logic [CNT_W-1:0]           cnt_n, idx;
  logic [LANES-1:0]           dout_n, seq_bits;
  logic                       done_n;
  logic [FRAME_LEN-1:0]       lane_v;

  // Edge pulse is registered so the bit lands on the 4th clk_main edge.
  always_ff @(posedge clk_main or posedge clr) begin
    if (clr) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1     <= clk_data;
      s2     <= s1;
      s3     <= s2;
      edge_q <= s2 & ~s3;
    end
  end

  always_ff @(posedge clk_main or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    snap_n   = snap;
    mode_n   = mode_r;
    cnt_n    = bit_cnt;
    dout_n   = data_out;
    done_n   = 1'b0;
    lane_v   = '0;
    seq_bits = '0;
    idx      = mode_r ? (LAST - bit_cnt) : bit_cnt;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_v      = snap[k*FRAME_LEN +: FRAME_LEN];
      seq_bits[k] = lane_v[idx];
    end

    if (abort) begin
      state_n = IDLE;
      dout_n  = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap_n  = array_in;
            mode_n  = msb_first;
            cnt_n   = '0;
            state_n = ARM;
          end
        end
        ARM, SHIFT: begin
          if (edge_q) begin
            dout_n = seq_bits;
            if (bit_cnt == LAST) begin
              done_n = 1'b1;
              cnt_n  = '0;
              if (continuous) begin
                snap_n  = array_in;
                mode_n  = msb_first;
                state_n = ARM;
              end else begin
                state_n = IDLE;
              end
            end else begin
              cnt_n   = bit_cnt + 1'b1;
              state_n = SHIFT;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_main or posedge clr) begin
    if (clr) begin
      snap       <= '0;
      mode_r     <= 1'b0;
      bit_cnt    <= '0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      snap       <= snap_n;
      mode_r     <= mode_n;
      bit_cnt    <= cnt_n;
      data_out   <= dout_n;
      frame_done <= done_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bit_serializer_mlane.sv
// Scoreboard bench for bit_serializer_mlane: every clk_data strobe pushes the
// expected post-edge outputs; a monitor pops them 4 clk_main edges later.
module tb_bit_serializer_mlane;

  localparam int FL = 96;

  logic          clk_main = 1'b0;
  logic          clr = 1'b1;
  logic          clk_data = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          msb_first = 1'b0;
  logic          continuous = 1'b0;
  logic [2*FL-1:0] array_in = '0;
  logic [1:0]    data_out;
  logic          busy;
  logic          frame_done;
  logic [6:0]    bit_cnt;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [6:0] cnt;
    logic [1:0] d;
  } exp_t;

  exp_t q[$];

  bit_serializer_mlane dut (
    .clk_main   (clk_main),
    .clr        (clr),
    .clk_data   (clk_data),
    .start      (start),
    .abort      (abort),
    .msb_first  (msb_first),
    .continuous (continuous),
    .array_in   (array_in),
    .data_out   (data_out),
    .busy       (busy),
    .frame_done (frame_done),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk_main = ~clk_main;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: tracks each clk_data rise and checks outputs after its 3rd and 4th edge.
  logic [3:0] pend;
  logic       prev_cd;
  logic [1:0] last_d = 2'b00;

  always @(posedge clk_main or posedge clr) begin
    if (clr) begin
      pend    <= '0;
      prev_cd <= 1'b0;
    end else begin
      pend    <= {pend[2:0], clk_data & ~prev_cd};
      prev_cd <= clk_data;
    end
  end

  always @(negedge clk_main) begin
    exp_t e;
    if (clr) begin
      last_d = 2'b00;
    end else begin
      if (pend[3]) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("edge_out", {21'd0, busy, frame_done, bit_cnt, data_out}, {21'd0, e});
          last_d = e.d;
        end
      end
      if (pend[2]) chk("hold_after_e3", {30'd0, data_out}, {30'd0, last_d});
      if (frame_done && !pend[3]) chk("spurious_done", 32'd1, 32'd0);
    end
  end

  task automatic strobe(input int period, input bit ab, input bit st);
    for (int i = 0; i < period; i++) begin
      @(negedge clk_main);
      clk_data = (i == 0);
      abort    = ab && (i == 3);
      start    = st && (i == 3);
    end
  endtask

  task automatic push_strobe(input logic [1:0] d, input logic bsy, input int period,
                             input bit ab, input bit st);
    exp_t e;
    e.d = d; e.done = 1'b0; e.cnt = 7'd0; e.busy = bsy;
    q.push_back(e);
    strobe(period, ab, st);
  endtask

  task automatic frame_part(input logic [2*FL-1:0] arr, input logic msb, input logic cont_end,
                            input int period, input int p0, input int p1);
    for (int p = p0; p < p1; p++) begin
      int idx;
      logic [2*FL-1:0] t;
      exp_t e;
      idx = msb ? (FL - 1 - p) : p;
      for (int k = 0; k < 2; k++) begin
        t = arr >> (k * FL + idx);
        e.d[k] = t[0];
      end
      e.done = (p == FL - 1);
      e.cnt  = (p == FL - 1) ? 7'd0 : 7'(p + 1);
      e.busy = !((p == FL - 1) && !cont_end);
      q.push_back(e);
      strobe(period, 1'b0, 1'b0);
    end
  endtask

  task automatic do_start(input logic [2*FL-1:0] arr, input logic msb, input logic cont);
    @(negedge clk_main);
    array_in = arr; msb_first = msb; continuous = cont; start = 1'b1;
    @(negedge clk_main);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*FL-1:0] arr_a, arr_d, arr_c1, arr_c2, arr_b;
    arr_a  = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 96'h5555_5555_5555_5555_5555_5555};
    arr_d  = {96'h0000_0000_0000_0000_0000_0001, 96'h8000_0000_0000_0000_0000_0000};
    arr_c1 = {96'hA5A5_0F0F_CDEF_89AB_4567_0123, 96'h0123_4567_89AB_CDEF_0F0F_A5A5};
    arr_c2 = {96'hFFFF_0000_FFFF_0000_1234_5678, 96'h8765_4321_0000_FFFF_0000_FFFF};
    arr_b  = {96'hDEAD_BEEF_0000_1111_2222_3333, 96'hCAFE_F00D_4444_5555_6666_7777};

    // Reset values
    @(negedge clk_main);
    chk("rst_data_out", {30'd0, data_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_bit_cnt", {25'd0, bit_cnt}, 32'd0);
    @(negedge clk_main);
    clr = 1'b0;

    // Ascending single-shot frame
    do_start(arr_a, 1'b0, 1'b0);
    frame_part(arr_a, 1'b0, 1'b0, 5, 0, FL);
    repeat (3) @(negedge clk_main);
    chk("asc_hold_last", {30'd0, data_out}, 32'h2);
    chk("asc_busy_low", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) push_strobe(2'b10, 1'b0, 5, 1'b0, 1'b0);

    // Descending frame, start while busy is ignored
    do_start(arr_d, 1'b1, 1'b0);
    frame_part(arr_d, 1'b1, 1'b0, 5, 0, 10);
    @(negedge clk_main);
    array_in = ~arr_d; msb_first = 1'b0; start = 1'b1;
    @(negedge clk_main);
    start = 1'b0;
    frame_part(arr_d, 1'b1, 1'b0, 5, 10, FL);
    repeat (3) @(negedge clk_main);
    chk("desc_cnt_zero", {25'd0, bit_cnt}, 32'd0);

    // Continuous: frame 2 takes the array and mode present at frame-1 end
    do_start(arr_c1, 1'b0, 1'b1);
    frame_part(arr_c1, 1'b0, 1'b1, 5, 0, 20);
    array_in = arr_c2; msb_first = 1'b1;
    frame_part(arr_c1, 1'b0, 1'b1, 5, 20, FL);
    continuous = 1'b0;
    array_in = arr_a;
    frame_part(arr_c2, 1'b1, 1'b0, 5, 0, FL);
    repeat (3) @(negedge clk_main);
    chk("cont_busy_low", {31'd0, busy}, 32'd0);

    // Abort coincident with edge 40
    do_start(arr_a, 1'b0, 1'b0);
    frame_part(arr_a, 1'b0, 1'b0, 5, 0, 39);
    push_strobe(2'b00, 1'b0, 5, 1'b1, 1'b0);
    repeat (2) @(negedge clk_main);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_cnt", {25'd0, bit_cnt}, 32'd0);
    for (int i = 0; i < 2; i++) push_strobe(2'b00, 1'b0, 5, 1'b0, 1'b0);

    // Start coincident with an edge, then a frame at the minimum 3-cycle spacing
    array_in = arr_b; msb_first = 1'b0; continuous = 1'b0;
    push_strobe(2'b00, 1'b1, 5, 1'b0, 1'b1);
    frame_part(arr_b, 1'b0, 1'b0, 3, 0, FL);
    repeat (6) @(negedge clk_main);
    chk("fast_busy_low", {31'd0, busy}, 32'd0);

    // Reset mid-frame, then strobes without start are ignored
    do_start(arr_a, 1'b0, 1'b0);
    frame_part(arr_a, 1'b0, 1'b0, 5, 0, 5);
    @(negedge clk_main);
    clr = 1'b1;
    #1;
    chk("clr_data_out", {30'd0, data_out}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_cnt", {25'd0, bit_cnt}, 32'd0);
    chk("clr_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk_main);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) push_strobe(2'b00, 1'b0, 5, 1'b0, 1'b0);

    repeat (8) @(negedge clk_main);
    chk("sb_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
